token_receiver: RTL and testbench

Sink end of the DDP output token channel, which is currently acknowledged by a direct send-to-ack tie-off. It accepts 62-bit tokens from the CUES output port over the 2-phase send/ack handshake and buffers them in a first-word-fall-through FIFO for a local reader. It counts tokens against an expected number and flags completion, giving the board an observable end-of-run indication.

---
 rtl/token_receiver.sv | 164 ++++++++++++++++
 tb/tb_token_receiver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/token_receiver.sv
// token_receiver
// Sink end of the DDP output token channel. Accepts 62-bit tokens from the
// CUES output port over a 2-phase send/ack handshake. Tokens are buffered in a
// first-word-fall-through FIFO for a local reader. The block counts accepted
// tokens against an expected number and flags completion.
//
// Ports:
//   clk              system clock
//   rstn             synchronous active-low reset (shared with CUES)
//   start_i_tr       arm/restart, rising-edge detected
//   expect_num_i_tr  tokens expected per run, 0 = unbounded
//   send_i_tr        2-phase request from CUES (asynchronous)
//   token_i_tr       bundled token, opr field in [31:0]
//   ack_o_tr         2-phase acknowledge to CUES
//   rd_en_i_tr       pop head token
//   rd_valid_o_tr    FIFO not empty
//   rd_token_o_tr    head token
//   count_o_tr       tokens accepted this run, saturating at 255
//   checksum_o_tr    running XOR of opr fields of accepted tokens
//   recv_done_o_tr   expected count reached
//   full_o_tr        FIFO full (back-pressure)
module token_receiver #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i_tr,
  input  logic [3:0]  expect_num_i_tr,
  input  logic        send_i_tr,
  input  logic [61:0] token_i_tr,
  output logic        ack_o_tr,
  input  logic        rd_en_i_tr,
  output logic        rd_valid_o_tr,
  output logic [61:0] rd_token_o_tr,
  output logic [7:0]  count_o_tr,
  output logic [31:0] checksum_o_tr,
  output logic        recv_done_o_tr,
  output logic        full_o_tr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_start_d;
  logic                   r_ack;
  logic [7:0]             r_count;
  logic [31:0]            r_csum;
  logic [61:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_occ;

  logic                   w_send_s;
  logic                   w_pending;
  logic                   w_start_edge;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_capture;
  logic                   w_pop;
  logic [7:0]             w_count_base;
  logic [7:0]             w_count_next;
  logic [31:0]            w_csum_base;
  logic [31:0]            w_csum_next;

  // A request phase is outstanding whenever the synchronized send level
  // differs from our acknowledge level.
  assign w_send_s     = r_sync[SYNC_STAGES-1];
  assign w_pending    = w_send_s ^ r_ack;
  assign w_start_edge = start_i_tr & ~r_start_d;

  // Full/empty come from the registered occupancy, so a pop on the same edge
  // does not unblock a capture; that capture lands one cycle later.
  assign w_full    = (r_occ == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_occ == '0);
  assign w_pop     = rd_en_i_tr & ~w_empty;
  assign w_capture = (r_state == RECV) & w_pending & ~w_full;

  // A start edge clears the run totals first; a capture on that same edge
  // then counts as the first token of the new run.
  always_comb begin
    w_count_base = w_start_edge ? 8'd0 : r_count;
    w_csum_base  = w_start_edge ? 32'd0 : r_csum;
    w_count_next = w_count_base;
    w_csum_next  = w_csum_base;
    if (w_capture) begin
      if (w_count_base != 8'hFF) begin
        w_count_next = w_count_base + 8'd1;
      end
      w_csum_next = w_csum_base ^ token_i_tr[31:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_edge) w_state_next = RECV;
      end
      RECV: begin
        if (w_capture && (expect_num_i_tr != 4'd0) &&
            (w_count_next == {4'd0, expect_num_i_tr})) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (w_start_edge) w_state_next = RECV;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_sync    <= '0;
      r_start_d <= 1'b0;
      r_ack     <= 1'b0;
      r_count   <= 8'd0;
      r_csum    <= 32'd0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_sync    <= {r_sync[SYNC_STAGES-2:0], send_i_tr};
      r_start_d <= start_i_tr;
      r_count   <= w_count_next;
      r_csum    <= w_csum_next;
      if (w_capture) begin
        r_ack    <= ~r_ack;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_capture, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Token storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= token_i_tr;
    end
  end

  assign ack_o_tr       = r_ack;
  assign rd_valid_o_tr  = ~w_empty;
  assign rd_token_o_tr  = r_mem[r_rd_ptr];
  assign count_o_tr     = r_count;
  assign checksum_o_tr  = r_csum;
  assign recv_done_o_tr = (r_state == DONE);
  assign full_o_tr      = w_full;

endmodule

// File: tb/tb_token_receiver.sv
// tb_token_receiver
// Self-checking bench for token_receiver. A behavioural model keeps the
// expected FIFO contents in a queue plus the run totals. It decides from the
// run state and queue size whether a request must be acknowledged.
module tb_token_receiver;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic [3:0]  expect_num;
  logic        send_i;
  logic [61:0] token_i;
  logic        ack;
  logic        rd_en;
  logic        rd_valid;
  logic [61:0] rd_token;
  logic [7:0]  count;
  logic [31:0] csum;
  logic        done;
  logic        full;

  always #5 clk = ~clk;

  token_receiver #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rstn(rstn), .start_i_tr(start_i), .expect_num_i_tr(expect_num),
    .send_i_tr(send_i), .token_i_tr(token_i), .ack_o_tr(ack),
    .rd_en_i_tr(rd_en), .rd_valid_o_tr(rd_valid), .rd_token_o_tr(rd_token),
    .count_o_tr(count), .checksum_o_tr(csum), .recv_done_o_tr(done),
    .full_o_tr(full)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [61:0] m_q[$];
  int          m_count;
  logic [31:0] m_csum;
  int          m_expect;
  bit          m_run;
  bit          m_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_count = 0;
    m_csum  = 32'd0;
    m_run   = 1'b0;
    m_done  = 1'b0;
  endfunction

  function automatic void m_start();
    m_count = 0;
    m_csum  = 32'd0;
    m_done  = 1'b0;
    m_run   = 1'b1;
  endfunction

  function automatic bit m_can_accept();
    return m_run && !m_done && (m_q.size() < DEPTH);
  endfunction

  function automatic void m_accept(input logic [61:0] t);
    m_q.push_back(t);
    if (m_count < 255) m_count++;
    m_csum ^= t[31:0];
    if (m_expect != 0 && m_count == m_expect) m_done = 1'b1;
  endfunction

  function automatic logic [61:0] rand_tok(input logic [31:0] opr);
    logic [61:0] t;
    t[61:32] = 30'($urandom());
    t[31:0]  = opr;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; send_i = 1'b0; start_i = 1'b0; rd_en = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    m_reset();
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    m_start();
  endtask

  task automatic set_expect(input int e);
    m_expect   = e;
    expect_num = 4'(e);
  endtask

  // Cycles until ack changes, or -1 when it does not change within limit.
  task automatic wait_ack(input int limit, output int n);
    logic a0;
    int   i;
    a0 = ack;
    n  = -1;
    i  = 0;
    while (n < 0 && i < limit) begin
      tick();
      i++;
      if (ack !== a0) n = i;
    end
  endtask

  task automatic send(input logic [61:0] t);
    token_i = t;
    send_i  = ~send_i;
  endtask

  task automatic send_expect_ack(input string tag, input logic [61:0] t);
    int n;
    send(t);
    wait_ack(SYNC + 4, n);
    chk({tag, "_lat"}, 64'(n), 64'(SYNC + 1));
    if (n > 0) m_accept(t);
    $display("txn %s tok=0x%h ack_lat=%0d count=%0d", tag, t, n, count);
  endtask

  task automatic pop_one(input string tag);
    chk({tag, "_valid"}, 64'(rd_valid), 64'(1));
    chk({tag, "_tok"}, 64'(rd_token), 64'(m_q[0]));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    void'(m_q.pop_front());
    $display("txn %s pop left=%0d", tag, m_q.size());
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(m_count));
    chk({tag, "_csum"},  64'(csum),  64'(m_csum));
    chk({tag, "_done"},  64'(done),  64'(m_done));
    chk({tag, "_full"},  64'(full),  64'(m_q.size() == DEPTH));
    chk({tag, "_valid"}, 64'(rd_valid), 64'(m_q.size() != 0));
  endtask

  task automatic drain(input string tag);
    while (m_q.size() > 0) pop_one(tag);
    chk({tag, "_empty"}, 64'(rd_valid), 64'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        a0;
    logic [61:0] t;
    token_i = '0;
    set_expect(0);
    do_reset();

    // Reset state
    chk("rst_ack", 64'(ack), 64'(0));
    chk_status("rst");

    // Three tokens, expect 3
    set_expect(3);
    do_start();
    for (int i = 0; i < 3; i++) send_expect_ack("t1", rand_tok(32'(1) << i));
    chk("t1_csum_const", 64'(csum), 64'h7);
    chk("t1_done_const", 64'(done), 64'(1));
    chk_status("t1");
    drain("t1_pop");

    // Unbounded run filling the FIFO
    set_expect(0);
    do_start();
    for (int i = 0; i < DEPTH; i++) send_expect_ack("t2", rand_tok($urandom()));
    chk("t2_full", 64'(full), 64'(1));
    for (int k = 0; k < 4; k++) begin
      t = rand_tok($urandom());
      send(t);
      wait_ack(8, n);
      chk("t2_blocked", 64'(n), 64'hFFFF_FFFF_FFFF_FFFF);
      a0 = ack;
      pop_one("t2_popfull");
      chk("t2_ack_held", 64'(ack), 64'(a0));
      chk("t2_notfull", 64'(full), 64'(0));
      wait_ack(3, n);
      chk("t2_late_cap", 64'(n), 64'(1));
      if (n > 0) m_accept(t);
      chk("t2_refull", 64'(full), 64'(1));
    end
    chk_status("t2");
    drain("t2_pop");

    // Token arriving while idle
    do_reset();
    set_expect(1);
    t = rand_tok($urandom());
    send(t);
    wait_ack(8, n);
    chk("t3_idle_noack", 64'(n), 64'hFFFF_FFFF_FFFF_FFFF);
    do_start();
    wait_ack(SYNC + 1, n);
    chk("t3_lat_ok", 64'(n >= 1 && n <= SYNC + 1), 64'(1));
    if (n > 0) m_accept(t);
    chk_status("t3");

    // DONE blocks a request, restart accepts it and keeps old FIFO entries
    set_expect(2);
    do_start();
    for (int i = 0; i < 2; i++) send_expect_ack("t4", rand_tok($urandom()));
    chk_status("t4_done");
    t = rand_tok($urandom());
    send(t);
    wait_ack(8, n);
    chk("t4_done_noack", 64'(n), 64'hFFFF_FFFF_FFFF_FFFF);
    do_start();
    wait_ack(SYNC + 1, n);
    chk("t4_restart_ack", 64'(n >= 1 && n <= SYNC + 1), 64'(1));
    if (n > 0) m_accept(t);
    chk_status("t4_restart");
    drain("t4_pop");

    // Randomized runs with random reads
    for (int r = 0; r < 8; r++) begin
      set_expect(int'($urandom_range(1, 6)));
      do_start();
      for (int k = 0; k <= m_expect; k++) begin
        for (int p = int'($urandom_range(0, 3)); p > 0 && m_q.size() > 0; p--) pop_one("rnd_pop");
        if (m_q.size() >= DEPTH) pop_one("rnd_popfull");
        t = rand_tok($urandom());
        if (m_can_accept()) begin
          send_expect_ack("rnd", t);
        end else begin
          send(t);
          wait_ack(8, n);
          chk("rnd_done_noack", 64'(n), 64'hFFFF_FFFF_FFFF_FFFF);
          chk("rnd_done_flag", 64'(done), 64'(1));
          do_start();
          wait_ack(SYNC + 1, n);
          chk("rnd_restart_ack", 64'(n >= 1 && n <= SYNC + 1), 64'(1));
          if (n > 0) m_accept(t);
        end
        chk_status("rnd");
      end
    end
    drain("rnd_drain");

    // Reset mid-run
    set_expect(0);
    do_start();
    for (int i = 0; i < 5; i++) send_expect_ack("t6", rand_tok($urandom()));
    chk_status("t6_pre");
    rstn = 1'b0; send_i = 1'b0;
    tick();
    chk("t6_ack", 64'(ack), 64'(0));
    chk("t6_valid", 64'(rd_valid), 64'(0));
    chk("t6_count", 64'(count), 64'(0));
    chk("t6_csum", 64'(csum), 64'(0));
    chk("t6_done", 64'(done), 64'(0));
    chk("t6_full", 64'(full), 64'(0));
    rstn = 1'b1;
    m_reset();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
